inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  IF stage: owns the PC, fetches instructions from instruction memory over a req/ack
//  handshake of variable latency, and fills the IF/ID register (if_valid/if_pc/if_inst).
//  It is steered by the hazard controller's fetch_stall/fetch_flush/fetch_branch/
//  fetch_branch_target, and returns fetch_done to that controller.
// PARAMETERS
//  DATA_WIDTH  32            datapath / address width
//  RESET_PC    32'h0000_0000 PC loaded on reset
// PORTS
//  clk                  in   1   clock
//  rst_n                in   1   reset, asynchronous, active-low
//  fetch_stall          in   1   hold IF/ID and PC
//  fetch_flush          in   1   load a bubble into IF/ID
//  fetch_branch         in   1   redirect PC (branch taken or exception/ERET load)
//  fetch_branch_target  in   DW  redirect address
//  fetch_done           out  1   instruction for current PC is held, ready to issue
//  imem_req             out  1   memory request; held until imem_ack
//  imem_addr            out  DW  request address; stable while imem_req
//  imem_ack             in   1   one-cycle pulse, imem_rdata valid
//  imem_rdata           in   DW  instruction word
//  if_valid             out  1   IF/ID holds a real instruction
//  if_pc                out  DW  PC of if_inst
//  if_inst              out  DW  instruction (`INST_NOP when bubble)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state IDLE, discard=0, imem_req=0, imem_addr=0, fetch_done=0,
//   if_valid=0, if_pc=0, if_inst=`INST_NOP. Reset mid-request drops the request.
//  FSM (registered outputs; fetch_done = state==HOLD, no comb path from inputs):
//   IDLE: imem_req<=1, imem_addr<=pc -> WAIT.
//   WAIT: on imem_ack: discard ? (discard<=0 -> IDLE) : (latch inst -> HOLD).
//         imem_req<=0 in the ack cycle. Outstanding request is never aborted.
//   HOLD: wait for issue or redirect.
//  Per-cycle priority on IF/ID and PC:
//   1 fetch_branch && !(target==pc && !discard): pc<=target; if_valid<=0,
//     if_inst<=NOP; WAIT -> discard<=1; HOLD -> IDLE. Redirect to the PC already
//     being fetched is a no-op (controller may hold fetch_branch several cycles).
//   2 fetch_flush: if_valid<=0, if_inst<=NOP; PC, FSM and held inst unchanged.
//   3 !fetch_stall && state==HOLD: if_inst<=held, if_pc<=pc, if_valid<=1,
//     pc<=pc+4 (mod 2^DW wrap), -> IDLE.
//   4 else IF/ID holds.
//  Latency: zero-wait memory (ack the cycle after req) -> one instruction per 3 cycles;
//   IDLE->WAIT->HOLD. Redirect during WAIT costs the remaining wait plus a full fetch.
//  Simultaneous ack + fetch_branch (new target): data discarded, -> IDLE at new pc.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined: extra port if_misaligned (out,1). pc[1:0]!=0 in
//   IDLE -> no memory request, -> HOLD with inst=`INST_NOP and a misaligned flag;
//   on issue if_misaligned<=1 (consumed by exception logic), reset 0.
//  Undefined: no port; pc<=target & ~3 on redirect, misalignment silently masked.
// STRUCTURE
//  defines.v: `DATA_BUS, `INST_NOP, fetch FSM state encodings (FETCH_IDLE/WAIT/HOLD).
//  One natural sub-module: fetch_mem_if (IDLE/WAIT/HOLD handshake + discard flag);
//   PC and IF/ID register stay in inst_fetch_unit.
// TESTING
//  Zero-wait mem, no stalls -> if_pc 0,4,8 issued at cycles 3,6,9; fetch_done 1 in HOLD.
//  ack delayed 5 cycles -> imem_req/imem_addr stable 5 cycles; fetch_done=0 throughout.
//  fetch_stall=1 for 4 cycles in HOLD -> if_* frozen, pc unchanged; releases -> pc+4.
//  fetch_branch target 0x100 during WAIT -> old data dropped, next if_pc=0x100, no
//   instruction from old pc ever has if_valid=1.
//  fetch_branch held 3 cycles to 0x200 -> single redirect, 0x200 fetched once.
//  rst_n low mid-WAIT -> all outputs at reset values immediately; refetch from RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_unit_pkg;

  localparam logic [31:0] INST_NOP   = 32'h0000_0000;
  localparam int          INST_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface inst_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/inst_fetch_unit_fetch_mem_if.sv
// Fetch handshake sequencer: issues one imem request per instruction and drops
// responses that belong to a redirected fetch. FETCH_MISALIGN_CHECK_EN adds misalign tagging.
//
// state      | meaning
// FETCH_IDLE | no request outstanding; launch one for pc next cycle
// FETCH_WAIT | request outstanding, waiting for imem_ack
// FETCH_HOLD | instruction for pc latched, waiting for issue or redirect
module inst_fetch_unit_fetch_mem_if
  import inst_fetch_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  redirect,
  input  logic                  issue,
  inst_fetch_unit_if.master     imem,
  output fetch_state_e          state,
  output logic                  discard,
  output logic [DATA_WIDTH-1:0] held_inst
`ifdef FETCH_MISALIGN_CHECK_EN
  ,output logic                 held_misaligned
`endif
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(INST_NOP);

  fetch_state_e          state_nxt;
  logic                  discard_nxt;
  logic                  req_q, req_nxt;
  logic [DATA_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] held_nxt;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic                  mis_nxt;
`endif

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH_IDLE;
      discard   <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      held_inst <= NOP;
`ifdef FETCH_MISALIGN_CHECK_EN
      held_misaligned <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      discard   <= discard_nxt;
      req_q     <= req_nxt;
      addr_q    <= addr_nxt;
      held_inst <= held_nxt;
`ifdef FETCH_MISALIGN_CHECK_EN
      held_misaligned <= mis_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    req_nxt     = req_q;
    addr_nxt    = addr_q;
    held_nxt    = held_inst;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_nxt     = held_misaligned;
`endif
    case (state)
      FETCH_IDLE: begin
        // A redirect here changes pc this cycle, so wait one cycle and request the new pc.
        if (!redirect) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (pc[1:0] != 2'b00) begin
            held_nxt  = NOP;
            mis_nxt   = 1'b1;
            state_nxt = FETCH_HOLD;
          end else
`endif
          begin
            req_nxt   = 1'b1;
            addr_nxt  = pc;
            state_nxt = FETCH_WAIT;
          end
        end
      end
      FETCH_WAIT: begin
        if (imem.imem_ack) begin
          req_nxt     = 1'b0;
          discard_nxt = 1'b0;
          if (discard || redirect) begin
            state_nxt = FETCH_IDLE;
          end else begin
            held_nxt  = imem.imem_rdata;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_nxt   = 1'b0;
`endif
            state_nxt = FETCH_HOLD;
          end
        end else if (redirect) begin
          discard_nxt = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (redirect || issue) state_nxt = FETCH_IDLE;
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// IF stage: owns the PC and the IF/ID register, fetching through inst_fetch_unit_fetch_mem_if.
// FETCH_MISALIGN_CHECK_EN adds if_misaligned; otherwise redirect targets are word-aligned.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_stall,
  input  logic                  fetch_flush,
  input  logic                  fetch_branch,
  input  logic [DATA_WIDTH-1:0] fetch_branch_target,
  output logic                  fetch_done,
  inst_fetch_unit_if.master     imem,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_inst
`ifdef FETCH_MISALIGN_CHECK_EN
  ,output logic                 if_misaligned
`endif
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(INST_NOP);

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] held_inst;
  fetch_state_e          state;
  logic                  discard;
  logic                  redirect;
  logic                  issue;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic                  held_misaligned;
  assign target = fetch_branch_target;
`else
  assign target = fetch_branch_target & ~DATA_WIDTH'(3);
`endif

  // The controller may hold fetch_branch for several cycles; re-targeting the pc
  // already being fetched must not restart the fetch.
  assign redirect   = fetch_branch && !((target == pc) && !discard);
  assign issue      = (state == FETCH_HOLD) && !redirect && !fetch_flush && !fetch_stall;
  assign fetch_done = (state == FETCH_HOLD);

  inst_fetch_unit_fetch_mem_if #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fetch_mem_if (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .redirect  (redirect),
    .issue     (issue),
    .imem      (imem),
    .state     (state),
    .discard   (discard),
    .held_inst (held_inst)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,.held_misaligned (held_misaligned)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target;
    end else if (issue) begin
      pc <= pc + DATA_WIDTH'(INST_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= NOP;
`ifdef FETCH_MISALIGN_CHECK_EN
      if_misaligned <= 1'b0;
`endif
    end else if (redirect || fetch_flush) begin
      if_valid <= 1'b0;
      if_inst  <= NOP;
`ifdef FETCH_MISALIGN_CHECK_EN
      if_misaligned <= 1'b0;
`endif
    end else if (issue) begin
      if_valid <= 1'b1;
      if_pc    <= pc;
      if_inst  <= held_inst;
`ifdef FETCH_MISALIGN_CHECK_EN
      if_misaligned <= held_misaligned;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed fetch scenarios with a
// variable-latency memory model and an issue scoreboard.
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        fetch_stall;
  logic        fetch_flush;
  logic        fetch_branch;
  logic [31:0] fetch_branch_target;
  logic        fetch_done;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        if_misaligned;
`endif

  int          n_chk;
  int          n_fail;
  int          mem_lat;
  int          req_cnt_200;
  logic [31:0] exp_q[$];

  inst_fetch_unit_if #(.DATA_WIDTH(32)) mem ();

  inst_fetch_unit #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_stall         (fetch_stall),
    .fetch_flush         (fetch_flush),
    .fetch_branch        (fetch_branch),
    .fetch_branch_target (fetch_branch_target),
    .fetch_done          (fetch_done),
    .imem                (mem),
    .if_valid            (if_valid),
    .if_pc               (if_pc),
    .if_inst             (if_inst)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,.if_misaligned      (if_misaligned)
`endif
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (k == budget) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_issue: timed out with %0d instructions still expected", exp_q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, {31'b0, mem.imem_req}, 32'd0);
    chk({tag, "_imem_addr"}, mem.imem_addr, 32'd0);
    chk({tag, "_fetch_done"}, {31'b0, fetch_done}, 32'd0);
    chk({tag, "_if_valid"}, {31'b0, if_valid}, 32'd0);
    chk({tag, "_if_pc"}, if_pc, 32'd0);
    chk({tag, "_if_inst"}, if_inst, NOP);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Memory model: acks mem_lat cycles after first seeing a request; reset drops it.
  initial begin
    bit busy;
    int cnt;
    busy = 1'b0;
    cnt  = 0;
    mem.imem_ack   = 1'b0;
    mem.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem.imem_ack = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (!busy && mem.imem_req) begin
        busy = 1'b1;
        cnt  = mem_lat;
        if (mem.imem_addr == 32'h200) req_cnt_200++;
      end
      if (busy && rst_n) begin
        if (cnt == 0) begin
          mem.imem_ack   = 1'b1;
          mem.imem_rdata = inst_of(mem.imem_addr);
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Issue monitor: every newly presented IF/ID instruction must match the queue head.
  initial begin
    logic        prev_v;
    logic [31:0] prev_pc;
    logic [31:0] e;
    prev_v  = 1'b0;
    prev_pc = '0;
    forever begin
      @(negedge clk);
      if (if_valid && !(prev_v && prev_pc == if_pc)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_issue: got pc %h with no instruction expected", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("issue_pc", if_pc, e);
          chk("issue_inst", if_inst, inst_of(e));
        end
      end
      prev_v  = if_valid;
      prev_pc = if_pc;
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    mem_lat = 0;
    req_cnt_200 = 0;
    rst_n = 1'b0;
    fetch_stall = 1'b0;
    fetch_flush = 1'b0;
    fetch_branch = 1'b0;
    fetch_branch_target = '0;

    repeat (2) step();
    chk_reset_outputs("reset");

    // Zero-wait memory: one issue every three cycles.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk($sformatf("tput_done_c%0d", i), {31'b0, fetch_done}, {31'b0, (i % 3) == 2});
      chk($sformatf("tput_req_c%0d", i), {31'b0, mem.imem_req}, {31'b0, (i % 3) == 1});
      chk($sformatf("tput_valid_c%0d", i), {31'b0, if_valid}, {31'b0, i >= 3});
      chk($sformatf("tput_pc_c%0d", i), if_pc, (i >= 3) ? 32'(4 * (i / 3 - 1)) : 32'h0);
    end

    // Stall four cycles in HOLD.
    fetch_stall = 1'b1;
    step();
    step();
    chk("stall_enter_hold", {31'b0, fetch_done}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_if_pc", if_pc, 32'h8);
      chk("stall_if_inst", if_inst, inst_of(32'h8));
      chk("stall_if_valid", {31'b0, if_valid}, 32'd1);
      chk("stall_done", {31'b0, fetch_done}, 32'd1);
    end
    fetch_stall = 1'b0;
    exp_q.push_back(32'hC);
    step();
    chk("stall_release_pc", if_pc, 32'hC);

    // Slow memory: request and address stable, fetch_done low while waiting.
    mem_lat = 5;
    exp_q.push_back(32'h10);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("slow_req", {31'b0, mem.imem_req}, 32'd1);
      chk("slow_addr", mem.imem_addr, 32'h10);
      chk("slow_done", {31'b0, fetch_done}, 32'd0);
    end
    step();
    chk("slow_hold", {31'b0, fetch_done}, 32'd1);
    mem_lat = 3;
    step();
    chk("slow_issue_pc", if_pc, 32'h10);

    // Redirect while WAIT: outstanding request completes but its data is dropped.
    step();
    fetch_branch = 1'b1;
    fetch_branch_target = 32'h100;
    step();
    fetch_branch = 1'b0;
    chk("wait_br_valid", {31'b0, if_valid}, 32'd0);
    chk("wait_br_inst", if_inst, NOP);
    chk("wait_br_req_kept", {31'b0, mem.imem_req}, 32'd1);
    chk("wait_br_addr_kept", mem.imem_addr, 32'h14);
    exp_q.push_back(32'h100);
    wait_empty(40);

    // Held redirect, first cycle coinciding with an ack.
    mem_lat = 0;
    step();
    fetch_branch = 1'b1;
    fetch_branch_target = 32'h200;
    step();
    chk("held_br_valid", {31'b0, if_valid}, 32'd0);
    chk("held_br_req_drop", {31'b0, mem.imem_req}, 32'd0);
    step();
    chk("held_br_req", {31'b0, mem.imem_req}, 32'd1);
    chk("held_br_addr", mem.imem_addr, 32'h200);
    step();
    chk("held_br_hold", {31'b0, fetch_done}, 32'd1);
    fetch_branch = 1'b0;
    exp_q.push_back(32'h200);
    wait_empty(20);
    chk("held_br_fetch_count", 32'(req_cnt_200), 32'd1);

    // Flush in HOLD: bubble, then the held instruction still issues.
    step();
    step();
    chk("flush_pre_done", {31'b0, fetch_done}, 32'd1);
    chk("flush_pre_valid", {31'b0, if_valid}, 32'd1);
    fetch_flush = 1'b1;
    step();
    fetch_flush = 1'b0;
    chk("flush_valid", {31'b0, if_valid}, 32'd0);
    chk("flush_inst", if_inst, NOP);
    chk("flush_done_kept", {31'b0, fetch_done}, 32'd1);
    exp_q.push_back(32'h204);
    wait_empty(20);

    // Reset during WAIT.
    mem_lat = 5;
    step();
    chk("rst_wait_addr", mem.imem_addr, 32'h208);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    step();
    step();
    mem_lat = 0;
    exp_q.push_back(32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_empty(20);

    // Redirect in HOLD to an unaligned target: low bits masked.
    step();
    chk("hold_br_addr", mem.imem_addr, 32'h4);
    step();
    chk("hold_br_done", {31'b0, fetch_done}, 32'd1);
    fetch_branch = 1'b1;
    fetch_branch_target = 32'h302;
    step();
    fetch_branch = 1'b0;
    chk("hold_br_valid", {31'b0, if_valid}, 32'd0);
    chk("hold_br_done_clr", {31'b0, fetch_done}, 32'd0);
    exp_q.push_back(32'h300);
    wait_empty(20);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
